// File: rtl/text_pkg.sv
// Shared constants and types for the 80x30 text RAM controller and its cursor.
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 12;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  // Slot cycle to disp_char: address register, RAM read, output register.
  localparam int FETCH_LAT = 3;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  typedef enum logic [2:0] {
    CUR_NONE = 3'd0,
    CUR_ADV  = 3'd1,
    CUR_CR   = 3'd2,
    CUR_LF   = 3'd3,
    CUR_HOME = 3'd4
  } cur_op_e;

endpackage

// File: rtl/text_cursor.sv
// Text cursor: column/row plus a linear cell address kept in step with them,
// so the write path never needs a row*COLS multiply.
module text_cursor
  import text_pkg::*;
#(
  parameter int COLS   = text_pkg::COLS,
  parameter int ROWS   = text_pkg::ROWS,
  parameter int ADDR_W = text_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  cur_op_e           op,
  output logic [6:0]        col,
  output logic [4:0]        row,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else begin
      case (op)
        CUR_ADV: begin
          if (col == LAST_COL) begin
            col <= '0;
            if (row == LAST_ROW) begin
              row  <= '0;
              addr <= '0;
            end else begin
              row  <= row + 5'd1;
              addr <= addr + ADDR_W'(1);
            end
          end else begin
            col  <= col + 7'd1;
            addr <= addr + ADDR_W'(1);
          end
        end
        CUR_CR: begin
          col  <= '0;
          addr <= addr - ADDR_W'(col);
        end
        CUR_LF: begin
          // Wrapping to row 0 leaves the address equal to the column.
          if (row == LAST_ROW) begin
            row  <= '0;
            addr <= ADDR_W'(col);
          end else begin
            row  <= row + 5'd1;
            addr <= addr + ADDR_W'(COLS);
          end
        end
        CUR_HOME: begin
          col  <= '0;
          row  <= '0;
          addr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_ram_ctrl.sv
// Sole master of the character RAM: arbitrates raster fetch, screen clear and
// character writes each clock, and owns the text cursor.
module text_ram_ctrl
  import text_pkg::*;
#(
  parameter int         COLS       = text_pkg::COLS,
  parameter int         ROWS       = text_pkg::ROWS,
  parameter logic [7:0] BLANK_CHAR = text_pkg::BLANK_CHAR,
  parameter int         ADDR_W     = text_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        CounterX,
  input  logic [9:0]        CounterY,
  input  logic              wr_valid,
  input  logic [7:0]        wr_char,
  output logic              wr_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [6:0]        cur_col,
  output logic [4:0]        cur_row,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        disp_char,
  output logic              disp_char_valid,
  output clr_state_e        dbg_clr_state
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  clr_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]       addr_d;
  logic                    we_d;
  logic [7:0]              wdata_d;
  cur_op_e                 cur_op;
  logic [ADDR_W-1:0]       cur_addr;
  logic [FETCH_LAT-2:0]    fetch_pipe;

  logic                    fetch_slot;
  logic [ADDR_W-1:0]       fetch_row;
  logic [ADDR_W-1:0]       fetch_addr;
  logic                    wr_fire;

  assign fetch_slot = (CounterX[2:0] == 3'd0) && (CounterX < 10'd640) && (CounterY < 10'd480);
  assign fetch_row  = ADDR_W'(CounterY[8:4]);
  assign fetch_addr = (fetch_row << 6) + (fetch_row << 4) + ADDR_W'(CounterX[9:3]);

  // Write handshake: a character transfers on a rising clk edge where both
  // wr_valid and wr_ready are high. wr_ready is combinational from reset,
  // clear state and the raster counters; the source must hold wr_valid and
  // wr_char stable until the transfer happens.
  assign wr_ready = !rst && !clr_busy && !fetch_slot;
  assign wr_fire  = wr_valid && wr_ready;

  assign clr_busy      = (state_q == CLR_CLEAR);
  assign dbg_clr_state = state_q;

  text_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk  (clk),
    .rst  (rst),
    .op   (cur_op),
    .col  (cur_col),
    .row  (cur_row),
    .addr (cur_addr)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    addr_d    = ram_addr;
    we_d      = 1'b0;
    wdata_d   = ram_wdata;
    cur_op    = CUR_NONE;

    if (state_q == CLR_IDLE && clr_req) begin
      state_d   = CLR_CLEAR;
      clr_cnt_d = '0;
    end

    // Port priority: fetch > clear > write.
    if (fetch_slot) begin
      addr_d = fetch_addr;
    end else if (state_q == CLR_CLEAR) begin
      addr_d  = clr_cnt_q;
      we_d    = 1'b1;
      wdata_d = BLANK_CHAR;
      if (clr_cnt_q == LAST_CELL) begin
        state_d   = CLR_IDLE;
        clr_cnt_d = '0;
        cur_op    = CUR_HOME;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      end
    end else if (wr_fire) begin
      case (wr_char)
        CHAR_CR: cur_op = CUR_CR;
        CHAR_LF: cur_op = CUR_LF;
        default: begin
          addr_d  = cur_addr;
          we_d    = 1'b1;
          wdata_d = wr_char;
          cur_op  = CUR_ADV;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= CLR_IDLE;
      clr_cnt_q       <= '0;
      ram_addr        <= '0;
      ram_we          <= 1'b0;
      ram_wdata       <= '0;
      fetch_pipe      <= '0;
      disp_char       <= '0;
      disp_char_valid <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      ram_addr        <= addr_d;
      ram_we          <= we_d;
      ram_wdata       <= wdata_d;
      fetch_pipe      <= {fetch_pipe[FETCH_LAT-3:0], fetch_slot};
      disp_char_valid <= fetch_pipe[FETCH_LAT-2];
      if (fetch_pipe[FETCH_LAT-2]) begin
        disp_char <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_text_ram_ctrl.sv
// Bench for text_ram_ctrl: RAM model, directed stimulus, and queue-based
// scoreboard for RAM writes and fetched characters.
module tb_text_ram_ctrl;
  import text_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  CounterX, CounterY;
  logic        wr_valid;
  logic [7:0]  wr_char;
  logic        wr_ready;
  logic        clr_req;
  logic        clr_busy;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  disp_char;
  logic        disp_char_valid;
  clr_state_e  dbg_clr_state;

  text_ram_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .CounterX        (CounterX),
    .CounterY        (CounterY),
    .wr_valid        (wr_valid),
    .wr_char         (wr_char),
    .wr_ready        (wr_ready),
    .clr_req         (clr_req),
    .clr_busy        (clr_busy),
    .cur_col         (cur_col),
    .cur_row         (cur_row),
    .ram_addr        (ram_addr),
    .ram_we          (ram_we),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata),
    .disp_char       (disp_char),
    .disp_char_valid (disp_char_valid),
    .dbg_clr_state   (dbg_clr_state)
  );

  // RAM model with 1-cycle read latency
  logic [7:0] mem [0:4095];
  logic       init_req;

  function automatic logic [7:0] pattern(input int i);
    return 8'((i * 37 + 11) ^ (i >> 8));
  endfunction

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (init_req) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pattern(i);
      mem[162] <= 8'h41;
    end else if (ram_we === 1'b1) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  // scoreboard state
  logic [19:0] exp_q[$];
  logic [7:0]  disp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        disp_check_en;
  logic        slot_at_edge = 1'b0;
  int          m_col, m_row;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk)
    slot_at_edge <= (CounterX[2:0] == 3'd0) && (CounterX < 10'd640) && (CounterY < 10'd480);

  // monitor
  always @(negedge clk) begin
    logic [19:0] e;
    if (ram_we === 1'b1) begin
      chk("write_on_fetch_slot", {31'd0, slot_at_edge}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {20'd0, ram_addr}, {20'd0, e[19:8]});
        chk("wr_data", {24'd0, ram_wdata}, {24'd0, e[7:0]});
      end
    end
    if (disp_char_valid === 1'b1 && disp_check_en) begin
      if (disp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_disp: got char 0x%0h, expected no pulse", disp_char);
      end else begin
        chk("disp_char", {24'd0, disp_char}, {24'd0, disp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cursor(input string name);
    chk({name, "_col"}, {25'd0, cur_col}, 32'(m_col));
    chk({name, "_row"}, {27'd0, cur_row}, 32'(m_row));
  endtask

  task automatic model_char(input logic [7:0] c);
    if (c == CHAR_CR) begin
      m_col = 0;
    end else if (c == CHAR_LF) begin
      m_row = (m_row == 29) ? 0 : m_row + 1;
    end else begin
      exp_q.push_back({12'(m_row * 80 + m_col), c});
      if (m_col == 79) begin
        m_col = 0;
        m_row = (m_row == 29) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
  endtask

  task automatic put_char(input logic [7:0] c);
    int n = 0;
    wr_valid = 1'b1;
    wr_char  = c;
    #1;
    while (wr_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
    if (wr_ready === 1'b1) model_char(c);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic raster_step();
    if (CounterX == 10'd799) begin
      CounterX = 10'd0;
      CounterY = (CounterY == 10'd524) ? 10'd0 : CounterY + 10'd1;
    end else begin
      CounterX = CounterX + 10'd1;
    end
  endtask

  initial begin
    int n;
    int bad;
    int bad_hi;
    logic found;

    rst = 1'b1; CounterX = 10'd0; CounterY = 10'd500;
    wr_valid = 1'b0; wr_char = 8'h00; clr_req = 1'b0;
    disp_check_en = 1'b1; init_req = 1'b1;
    m_col = 0; m_row = 0;
    repeat (3) tick();
    init_req = 1'b0;

    // reset values
    chk("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    chk("rst_disp_char", {24'd0, disp_char}, 32'd0);
    chk("rst_disp_valid", {31'd0, disp_char_valid}, 32'd0);
    chk("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_state", {31'd0, dbg_clr_state}, {31'd0, CLR_IDLE});
    chk_cursor("rst_cursor");
    rst = 1'b0;
    tick();

    // raster fetch at (16,32) -> cell 2*80+2 = 162
    CounterX = 10'd16; CounterY = 10'd32;
    disp_q.push_back(8'h41);
    tick();
    chk("fetch_addr", {20'd0, ram_addr}, 32'd162);
    chk("fetch_we", {31'd0, ram_we}, 32'd0);
    chk("fetch_valid_t1", {31'd0, disp_char_valid}, 32'd0);
    CounterY = 10'd500;
    tick();
    chk("fetch_valid_t2", {31'd0, disp_char_valid}, 32'd0);
    tick();
    chk("fetch_valid_t3", {31'd0, disp_char_valid}, 32'd1);
    tick();
    chk("fetch_valid_t4", {31'd0, disp_char_valid}, 32'd0);

    // write held across a fetch slot at (24,16) -> cell 1*80+3 = 83
    CounterX = 10'd24; CounterY = 10'd16;
    wr_valid = 1'b1; wr_char = 8'h77;
    disp_q.push_back(pattern(83));
    #1;
    chk("hold_ready_slot", {31'd0, wr_ready}, 32'd0);
    tick();
    chk("hold_fetch_addr", {20'd0, ram_addr}, 32'd83);
    chk("hold_fetch_we", {31'd0, ram_we}, 32'd0);
    CounterX = 10'd25;
    #1;
    chk("hold_ready_after", {31'd0, wr_ready}, 32'd1);
    model_char(8'h77);
    tick();
    wr_valid = 1'b0;
    CounterY = 10'd500;
    repeat (4) tick();
    chk_cursor("hold_cursor");

    // end-of-row wrap: write 0x30 at (79,0)
    while (m_col != 79) put_char(8'(8'h40 + m_col));
    chk_cursor("at_79_0");
    put_char(8'h30);
    chk_cursor("after_79_0");
    tick();
    chk("ram79", {24'd0, mem[79]}, 32'h30);

    // end-of-screen wrap at (79,29)
    repeat (28) put_char(CHAR_LF);
    chk_cursor("lf_to_29");
    while (m_col != 79) put_char(8'(8'h21 + m_col));
    chk_cursor("at_79_29");
    put_char(8'h5A);
    chk_cursor("after_79_29");

    // CR at (12,5)
    repeat (5) put_char(CHAR_LF);
    repeat (12) put_char(8'h62);
    chk_cursor("at_12_5");
    put_char(CHAR_CR);
    chk_cursor("after_cr");
    chk("cr_no_we", {31'd0, ram_we}, 32'd0);
    put_char(8'h78);

    // LF at (12,29)
    repeat (11) put_char(8'h63);
    repeat (24) put_char(CHAR_LF);
    chk_cursor("at_12_29");
    put_char(CHAR_LF);
    chk_cursor("after_lf_wrap");
    chk("lf_no_we", {31'd0, ram_we}, 32'd0);
    put_char(8'h79);
    repeat (3) tick();

    // clear requested together with a write: write goes first
    wr_valid = 1'b1; wr_char = 8'h55; clr_req = 1'b1;
    #1;
    chk("clr_same_cycle_ready", {31'd0, wr_ready}, 32'd1);
    model_char(8'h55);
    for (int i = 0; i < 2400; i++) exp_q.push_back({12'(i), BLANK_CHAR});
    tick();
    wr_valid = 1'b0; clr_req = 1'b0;
    chk("clr_busy_start", {31'd0, clr_busy}, 32'd1);
    chk("clr_ready_low", {31'd0, wr_ready}, 32'd0);
    chk("clr_state", {31'd0, dbg_clr_state}, {31'd0, CLR_CLEAR});

    // run the raster during the clear so fetch slots interleave
    disp_check_en = 1'b0;
    CounterX = 10'd0; CounterY = 10'd0;
    n = 0;
    while (clr_busy === 1'b1 && n < 6000) begin
      tick();
      raster_step();
      n++;
    end
    chk("clear_done", {31'd0, clr_busy}, 32'd0);
    m_col = 0; m_row = 0;
    chk_cursor("clear_home");
    CounterY = 10'd500;
    repeat (5) tick();
    disp_check_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 2400; i++) if (mem[i] !== BLANK_CHAR) bad++;
    chk("clear_cells_not_blank", 32'(bad), 32'd0);
    chk("clear_exp_drained", 32'(exp_q.size()), 32'd0);

    // reset aborts a clear after 1000 writes
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    tick();
    clr_req = 1'b1;
    for (int i = 0; i < 1000; i++) exp_q.push_back({12'(i), BLANK_CHAR});
    tick();
    clr_req = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 3000) begin
      if (ram_we === 1'b1 && ram_addr == 12'd999) found = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    chk("abort_reached", {31'd0, found}, 32'd1);
    rst = 1'b1;
    wr_valid = 1'b1; wr_char = 8'h66;
    #1;
    chk("rst_blocks_ready", {31'd0, wr_ready}, 32'd0);
    tick();
    chk("abort_busy", {31'd0, clr_busy}, 32'd0);
    chk("abort_we", {31'd0, ram_we}, 32'd0);
    chk("abort_state", {31'd0, dbg_clr_state}, {31'd0, CLR_IDLE});
    rst = 1'b0;
    wr_valid = 1'b0;
    m_col = 0; m_row = 0;
    repeat (3) tick();
    chk_cursor("abort_cursor");
    bad = 0;
    bad_hi = 0;
    for (int i = 0; i < 1000; i++) if (mem[i] !== BLANK_CHAR) bad++;
    for (int i = 1000; i < 2400; i++) if (mem[i] !== pattern(i)) bad_hi++;
    chk("abort_low_cells", 32'(bad), 32'd0);
    chk("abort_high_cells", 32'(bad_hi), 32'd0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("disp_q_empty", 32'(disp_q.size()), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
